// File: rtl/spi_slave_m1.sv
// spi_slave_m1 -- SPI mode 1 (CPOL=0, CPHA=1) slave, fully clocked by clk.
//
// sclk/ss/mosi are oversampled through SYNC_STAGES flops; sclk/ss edges are
// found by comparing the synchronised sample with its one-clk-old copy.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   sclk, ss, mosi    SPI master inputs (asynchronous to clk, ss active-low)
//   miso, miso_oe     serial data out (MSB first) and its tri-state enable
//   tx_data/tx_valid  byte offered to the one-entry TX holding buffer
//   tx_ready          TX holding buffer empty
//   rx_data/rx_valid  last received byte and its one-clk update strobe
//   busy              frame in progress (state ACTIVE)
//   tx_underrun       IDLE_BYTE loaded because the buffer was empty (pulse)
//   frame_err         ss released mid-byte (pulse)
module spi_slave_m1 #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       tx_underrun,
  output logic       frame_err
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic       sclk_d, ss_d;
  logic       sclk_s, ss_s, mosi_s;
  logic       sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic [1:0] warm;
  logic       armed;

  logic [7:0] shift_reg, rx_shift, buf_data, tx_word;
  logic [2:0] bit_cnt;
  logic       buf_full, reload_pend, miso_r;
  logic       start, stop, rise_act, fall_act, load_tx, byte_done, wr;

  // Input synchronisers and edge-detect history
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // The ss chain is preset high by reset; if the master still holds ss low
  // the chain would later show a false falling edge. Only arm ss_fall once
  // the chain has flushed and a genuine high level has been observed.
  always_ff @(posedge clk) begin
    if (reset) begin
      warm  <= '0;
      armed <= 1'b0;
    end else begin
      if (warm != 2'd3) warm <= warm + 2'd1;
      if (warm == 2'd3 && ss_s) armed <= 1'b1;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = armed & ss_d & ~ss_s;
  assign ss_rise   = ~ss_d & ss_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_n  = state;
    start    = 1'b0;
    stop     = 1'b0;
    rise_act = 1'b0;
    fall_act = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_n = ACTIVE;
          start   = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_n = IDLE;
          stop    = 1'b1;
        end else begin
          rise_act = sclk_rise;
          fall_act = sclk_fall;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Between back-to-back bytes the next TX byte is fetched on the first
  // sclk rise of the new byte rather than at the 8th fall, so a byte queued
  // in response to rx_valid still makes it onto the wire.
  assign load_tx   = start | (rise_act & reload_pend);
  assign byte_done = fall_act & (bit_cnt == 3'd7);
  assign tx_word   = buf_full ? buf_data : IDLE_BYTE;
  assign wr        = tx_valid & ~buf_full;

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg   <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      buf_data    <= '0;
      bit_cnt     <= '0;
      buf_full    <= 1'b0;
      reload_pend <= 1'b0;
      miso_r      <= 1'b0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      tx_underrun <= load_tx & ~buf_full;
      frame_err   <= stop & (bit_cnt != 3'd0);
      rx_valid    <= byte_done;
      // Consume sees the old content; a same-cycle write refills the buffer.
      buf_full    <= wr | (buf_full & ~load_tx);
      if (wr) buf_data <= tx_data;

      if (start) begin
        shift_reg   <= tx_word;
        bit_cnt     <= '0;
        reload_pend <= 1'b0;
        miso_r      <= 1'b0;
      end

      if (stop) begin
        bit_cnt     <= '0;
        rx_shift    <= '0;
        reload_pend <= 1'b0;
        miso_r      <= 1'b0;
      end

      if (rise_act) begin
        if (reload_pend) begin
          miso_r      <= tx_word[7];
          shift_reg   <= {tx_word[6:0], 1'b0};
          reload_pend <= 1'b0;
        end else begin
          miso_r    <= shift_reg[7];
          shift_reg <= {shift_reg[6:0], 1'b0};
        end
      end

      if (fall_act) begin
        rx_shift <= {rx_shift[6:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data     <= {rx_shift[6:0], mosi_s};
          reload_pend <= 1'b1;
        end
      end
    end
  end

  assign busy     = (state == ACTIVE);
  assign miso_oe  = busy;
  assign miso     = miso_r;
  assign tx_ready = ~buf_full;

endmodule

// File: tb/tb_spi_slave_m1.sv
module tb_spi_slave_m1;

  logic       clk = 1'b0;
  logic       reset, sclk, ss, mosi, tx_valid;
  logic [7:0] tx_data;
  logic       miso, miso_oe, tx_ready, rx_valid, busy, tx_underrun, frame_err;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  spi_slave_m1 #(.SYNC_STAGES(2), .IDLE_BYTE(8'h00)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .tx_underrun(tx_underrun), .frame_err(frame_err)
  );

  int total = 0;
  int bad   = 0;
  int rxv_n = 0;
  int und_n = 0;
  int ferr_n = 0;
  logic [7:0] sb[$];

  typedef struct {
    bit         q_en;
    logic [7:0] txb;
    logic [7:0] mosi_b;
    logic [7:0] exp_miso;
    int         exp_und;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clk step, sampled on the falling edge; scoreboard and pulse counters.
  task automatic tick();
    @(negedge clk);
    if (rx_valid) begin
      rxv_n++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected: got rx_data %h expected no rx_valid", rx_data);
      end else begin
        chk("rx_scoreboard", {24'h0, rx_data}, {24'h0, sb.pop_front()});
      end
    end
    if (tx_underrun) und_n++;
    if (frame_err) ferr_n++;
  endtask

  task automatic queue_tx(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
  endtask

  task automatic ss_low();
    ss = 1'b0;
    repeat (6) tick();
  endtask

  task automatic ss_high();
    ss = 1'b1;
    repeat (8) tick();
  endtask

  // Master: drive mosi with sclk rise, sample miso just before sclk fall.
  task automatic shift_byte(input logic [7:0] b, input int nbits, output logic [7:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      mosi = b[7-i];
      repeat (5) tick();
      got  = {got[6:0], miso};
      sclk = 1'b0;
      repeat (5) tick();
    end
  endtask

  initial begin
    logic [7:0] g1, g2;
    int r0, u0, f0;

    vecs[0] = '{1'b1, 8'hC5, 8'h3A, 8'hC5, 0};
    vecs[1] = '{1'b0, 8'h00, 8'hFF, 8'h00, 1};
    vecs[2] = '{1'b1, 8'h80, 8'h01, 8'h80, 0};
    vecs[3] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 0};
    vecs[4] = '{1'b1, 8'h5A, 8'hA5, 8'h5A, 0};

    reset = 1'b1; sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_outputs",
        {17'h0, miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun, frame_err},
        {17'h0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    repeat (6) tick();

    // Single frames from the vector table
    for (int v = 0; v < 5; v++) begin
      r0 = rxv_n; u0 = und_n; f0 = ferr_n;
      if (vecs[v].q_en) begin
        queue_tx(vecs[v].txb);
        chk("tx_ready_full", {31'h0, tx_ready}, 32'h0);
      end
      sb.push_back(vecs[v].mosi_b);
      ss_low();
      chk("busy_active", {30'h0, busy, miso_oe}, 32'h3);
      chk("tx_ready_after_load", {31'h0, tx_ready}, 32'h1);
      shift_byte(vecs[v].mosi_b, 8, g1);
      ss_high();
      chk("miso_byte", {24'h0, g1}, {24'h0, vecs[v].exp_miso});
      chk("rx_data", {24'h0, rx_data}, {24'h0, vecs[v].mosi_b});
      chk("rx_valid_count", rxv_n - r0, 1);
      chk("underrun_count", und_n - u0, vecs[v].exp_und);
      chk("frame_err_none", ferr_n - f0, 0);
      chk("idle_outputs", {29'h0, busy, miso_oe, miso}, 32'h0);
    end

    // Two bytes under one ss, second TX byte queued after first rx_valid
    r0 = rxv_n; u0 = und_n;
    queue_tx(8'h11);
    sb.push_back(8'hA3);
    sb.push_back(8'h5C);
    ss_low();
    shift_byte(8'hA3, 8, g1);
    repeat (4) tick();
    chk("b2b_first_rx", rxv_n - r0, 1);
    queue_tx(8'h22);
    shift_byte(8'h5C, 8, g2);
    ss_high();
    chk("b2b_miso0", {24'h0, g1}, 32'h11);
    chk("b2b_miso1", {24'h0, g2}, 32'h22);
    chk("b2b_rx_count", rxv_n - r0, 2);
    chk("b2b_no_underrun", und_n - u0, 0);

    // ss released after 5 bits
    r0 = rxv_n; f0 = ferr_n;
    ss_low();
    shift_byte(8'hF0, 5, g1);
    ss_high();
    chk("ferr_count", ferr_n - f0, 1);
    chk("ferr_no_rx", rxv_n - r0, 0);
    chk("ferr_rx_kept", {24'h0, rx_data}, 32'h5C);
    r0 = rxv_n; f0 = ferr_n;
    sb.push_back(8'h0F);
    ss_low();
    shift_byte(8'h0F, 8, g1);
    ss_high();
    chk("after_ferr_rx", {24'h0, rx_data}, 32'h0F);
    chk("after_ferr_rx_count", rxv_n - r0, 1);
    chk("after_ferr_no_err", ferr_n - f0, 0);

    // Reset for one clk mid-frame; ss stays low through the rest of the byte
    ss_low();
    shift_byte(8'hE0, 3, g1);
    chk("busy_before_reset", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midframe_reset_outputs",
        {17'h0, miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun, frame_err},
        {17'h0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    r0 = rxv_n; f0 = ferr_n;
    shift_byte(8'h1F, 5, g1);
    chk("post_reset_idle", {31'h0, busy}, 32'h0);
    ss_high();
    chk("post_reset_no_ferr", ferr_n - f0, 0);
    chk("post_reset_no_rx", rxv_n - r0, 0);
    sb.push_back(8'h96);
    ss_low();
    shift_byte(8'h96, 8, g1);
    ss_high();
    chk("post_reset_rx", {24'h0, rx_data}, 32'h96);
    chk("post_reset_rx_count", rxv_n - r0, 1);

    // Write while full is dropped
    queue_tx(8'h44);
    chk("full_ready_low", {31'h0, tx_ready}, 32'h0);
    queue_tx(8'h77);
    chk("full_ready_still_low", {31'h0, tx_ready}, 32'h0);
    u0 = und_n;
    sb.push_back(8'h12);
    ss_low();
    shift_byte(8'h12, 8, g1);
    ss_high();
    chk("kept_byte_miso", {24'h0, g1}, 32'h44);
    chk("kept_byte_no_underrun", und_n - u0, 0);
    u0 = und_n;
    sb.push_back(8'h34);
    ss_low();
    shift_byte(8'h34, 8, g1);
    ss_high();
    chk("dropped_byte_miso", {24'h0, g1}, 32'h00);
    chk("dropped_byte_underrun", und_n - u0, 1);

    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
